bist_dr_ctrl: RTL and testbench



---
 rtl/bist_dr_ctrl_if.sv | 28 ++
 rtl/bist_dr_ctrl.sv | 145 ++++++++++++++
 tb/tb_bist_dr_ctrl.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/bist_dr_ctrl_if.sv
// TAP-side and BIST-engine-side signals of the RUNBIST data register controller.
// The slave modport is the controller; the master modport is the TAP plus the engine.
interface bist_dr_ctrl_if #(
    parameter int DUR_W = 5
);
    logic             sel_i;
    logic             capture_dr_i;
    logic             shift_dr_i;
    logic             update_dr_i;
    logic             tdi_i;
    logic             tdo_o;
    logic             tst_start_o;
    logic             pattern_sel_o;
    logic             success_i;
    logic [DUR_W-1:0] duration_i;

    modport master (
        output sel_i, capture_dr_i, shift_dr_i, update_dr_i, tdi_i,
        output success_i, duration_i,
        input  tdo_o, tst_start_o, pattern_sel_o
    );

    modport slave (
        input  sel_i, capture_dr_i, shift_dr_i, update_dr_i, tdi_i,
        input  success_i, duration_i,
        output tdo_o, tst_start_o, pattern_sel_o
    );
endinterface

// File: rtl/bist_dr_ctrl.sv
// RUNBIST test data register and run sequencer in front of the BIST engine.
// Optional BIST_FAIL_CNT_EN adds a saturating failed-run counter at DR[12:9].
//
// state  | meaning
// IDLE   | no run since reset, waiting for an accepted go
// START  | one-cycle tst_start_o pulse, timeout counter cleared
// RUN    | engine running; ends on duration==BIST_LEN or timeout
// SETTLE | one cycle for the engine's final success bit, then latch results
// DONE   | results held; a new go is accepted
module bist_dr_ctrl #(
    parameter int BIST_LEN = 17,
    parameter int DUR_W    = 5,
    parameter int TIMEOUT  = 63
) (
    input logic          clk,
    input logic          trst_n,
    bist_dr_ctrl_if.slave bus
);
    localparam int TMO_W = $clog2(TIMEOUT + 1);
`ifdef BIST_FAIL_CNT_EN
    localparam int DR_W  = 4 + DUR_W + 4;
`else
    localparam int DR_W  = 4 + DUR_W;
`endif

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_RUN    = 3'd2;
    localparam logic [2:0] S_SETTLE = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    logic [2:0]       r_state;
    logic [DR_W-1:0]  r_dr;
    logic             r_done;
    logic             r_pass;
    logic             r_tmo;
    logic [DUR_W-1:0] r_dur_lat;
    logic [TMO_W-1:0] r_tmo_ctr;
    logic             r_pattern;
    logic             r_tst_start;

    logic             w_busy;
    logic             w_go_accept;
    logic             w_len_hit;
    logic             w_tmo_hit;
    logic [DR_W-1:0]  w_status;

    assign w_busy      = (r_state == S_START) || (r_state == S_RUN) || (r_state == S_SETTLE);
    assign w_go_accept = bus.sel_i && bus.update_dr_i && r_dr[0] &&
                         ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_len_hit   = (bus.duration_i == DUR_W'(BIST_LEN));
    assign w_tmo_hit   = (r_tmo_ctr == TMO_W'(TIMEOUT));

`ifdef BIST_FAIL_CNT_EN
    logic [3:0] r_fail_cnt;
    logic       w_fail_evt;
    logic       w_fail_clr;

    assign w_fail_evt = ((r_state == S_RUN) && !w_len_hit && w_tmo_hit) ||
                        ((r_state == S_SETTLE) && !bus.success_i);
    assign w_fail_clr = w_go_accept && r_dr[2];
    assign w_status   = {r_fail_cnt, r_dur_lat, r_tmo, r_pass, r_done, w_busy};

    // Clearing and counting never coincide: a go is only accepted outside RUN/SETTLE.
    always_ff @(posedge clk or negedge trst_n) begin
        if (!trst_n) begin
            r_fail_cnt <= 4'd0;
        end else if (w_fail_clr) begin
            r_fail_cnt <= 4'd0;
        end else if (w_fail_evt && (r_fail_cnt != 4'hF)) begin
            r_fail_cnt <= r_fail_cnt + 4'd1;
        end
    end
`else
    assign w_status = {r_dur_lat, r_tmo, r_pass, r_done, w_busy};
`endif

    always_ff @(posedge clk or negedge trst_n) begin
        if (!trst_n) begin
            r_dr <= '0;
        end else if (bus.sel_i && bus.capture_dr_i) begin
            r_dr <= w_status;
        end else if (bus.sel_i && bus.shift_dr_i) begin
            r_dr <= {bus.tdi_i, r_dr[DR_W-1:1]};
        end
    end

    always_ff @(posedge clk or negedge trst_n) begin
        if (!trst_n) begin
            r_state     <= S_IDLE;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_tmo       <= 1'b0;
            r_dur_lat   <= '0;
            r_tmo_ctr   <= '0;
            r_pattern   <= 1'b0;
            r_tst_start <= 1'b0;
        end else begin
            // The pulse is high exactly in START, which is only entered from an accepted go.
            r_tst_start <= w_go_accept;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_go_accept) begin
                        r_pattern <= r_dr[1];
                        r_done    <= 1'b0;
                        r_pass    <= 1'b0;
                        r_tmo     <= 1'b0;
                        r_state   <= S_START;
                    end
                end
                S_START: begin
                    r_tmo_ctr <= '0;
                    r_state   <= S_RUN;
                end
                S_RUN: begin
                    if (!w_tmo_hit) begin
                        r_tmo_ctr <= r_tmo_ctr + 1'b1;
                    end
                    if (w_len_hit) begin
                        r_state <= S_SETTLE;
                    end else if (w_tmo_hit) begin
                        r_tmo     <= 1'b1;
                        r_pass    <= 1'b0;
                        r_done    <= 1'b1;
                        r_dur_lat <= bus.duration_i;
                        r_state   <= S_DONE;
                    end
                end
                S_SETTLE: begin
                    r_pass    <= bus.success_i;
                    r_dur_lat <= bus.duration_i;
                    r_done    <= 1'b1;
                    r_state   <= S_DONE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.tdo_o         = r_dr[0];
    assign bus.tst_start_o   = r_tst_start;
    assign bus.pattern_sel_o = r_pattern;
endmodule

// File: tb/tb_bist_dr_ctrl.sv
// Directed bench for bist_dr_ctrl with a counting BIST engine model and a status scoreboard.
module tb_bist_dr_ctrl;
`ifdef BIST_FAIL_CNT_EN
    localparam int DR_W = 13;
`else
    localparam int DR_W = 9;
`endif

    logic clk;
    logic trst_n;

    bist_dr_ctrl_if #(.DUR_W(5)) bus ();

    bist_dr_ctrl #(.BIST_LEN(17), .DUR_W(5), .TIMEOUT(63)) dut (
        .clk    (clk),
        .trst_n (trst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Engine model: restarts its counter on tst_start and counts up to eng_limit, then holds.
    logic [4:0] eng_dur;
    logic       eng_run;
    logic [4:0] eng_limit;

    always_ff @(posedge clk or negedge trst_n) begin
        if (!trst_n) begin
            eng_dur <= 5'd0;
            eng_run <= 1'b0;
        end else if (bus.tst_start_o) begin
            eng_dur <= 5'd0;
            eng_run <= 1'b1;
        end else if (eng_run && (eng_dur != eng_limit)) begin
            eng_dur <= eng_dur + 5'd1;
        end else begin
            eng_run <= 1'b0;
        end
    end
    assign bus.duration_i = eng_dur;

    int   start_cnt = 0;
    logic last_pat  = 1'b0;
    always @(posedge clk) begin
        if (bus.tst_start_o) begin
            start_cnt = start_cnt + 1;
            last_pat  = bus.pattern_sel_o;
        end
    end

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [3:0]  fc_model = 4'd0;
    logic [12:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [12:0] exp_st(input logic busy, input logic done, input logic pass,
                                           input logic tmo, input logic [4:0] dur);
`ifdef BIST_FAIL_CNT_EN
        return {fc_model, dur, tmo, pass, done, busy};
`else
        return {4'd0, dur, tmo, pass, done, busy};
`endif
    endfunction

    task automatic fail_bump();
        if (fc_model != 4'hF) fc_model = fc_model + 4'd1;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic shift_bits(input logic [12:0] din, output logic [12:0] dout);
        dout = '0;
        @(negedge clk);
        for (int i = 0; i < DR_W; i++) begin
            dout[i]          = bus.tdo_o;
            bus.shift_dr_i   = 1'b1;
            bus.tdi_i        = din[i];
            @(negedge clk);
        end
        bus.shift_dr_i = 1'b0;
        bus.tdi_i      = 1'b0;
    endtask

    task automatic read_status(output logic [12:0] st);
        @(negedge clk);
        bus.capture_dr_i = 1'b1;
        @(negedge clk);
        bus.capture_dr_i = 1'b0;
        shift_bits(13'd0, st);
    endtask

    task automatic do_go(input logic [2:0] ctrl);
        logic [12:0] unused_out;
        shift_bits({10'd0, ctrl}, unused_out);
        @(negedge clk);
        bus.update_dr_i = 1'b1;
        @(negedge clk);
        bus.update_dr_i = 1'b0;
    endtask

    task automatic check_sb(input string tag);
        logic [12:0] st;
        logic [12:0] ex;
        read_status(st);
        if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s scoreboard empty observed=0x%0h", tag, st);
        end else begin
            ex = exp_q.pop_front();
            check(tag, 32'(st), 32'(ex));
        end
    endtask

    logic [12:0] st_mid;
    int          s0;

    initial begin
        bus.sel_i        = 1'b0;
        bus.capture_dr_i = 1'b0;
        bus.shift_dr_i   = 1'b0;
        bus.update_dr_i  = 1'b0;
        bus.tdi_i        = 1'b0;
        bus.success_i    = 1'b1;
        eng_limit        = 5'd17;
        trst_n           = 1'b0;
        wait_cycles(3);
        trst_n = 1'b1;

        check("reset_tdo", 32'(bus.tdo_o), 32'd0);
        check("reset_tst_start", 32'(bus.tst_start_o), 32'd0);
        check("reset_pattern_sel", 32'(bus.pattern_sel_o), 32'd0);

        bus.sel_i = 1'b1;
        exp_q.push_back(exp_st(0, 0, 0, 0, 5'd0));
        check_sb("reset_status");
        check("no_start_after_reset", 32'(start_cnt), 32'd0);

        // Passing run with pattern_sel=1
        s0 = start_cnt;
        exp_q.push_back(exp_st(0, 1, 1, 0, 5'd17));
        do_go(3'b011);
        wait_cycles(40);
        check("pass_one_pulse", 32'(start_cnt - s0), 32'd1);
        check("pass_pulse_pattern", 32'(last_pat), 32'd1);
        check("pattern_sel_held", 32'(bus.pattern_sel_o), 32'd1);
        check_sb("pass_status");

        // Failing run with pattern_sel=0
        bus.success_i = 1'b0;
        s0 = start_cnt;
        fail_bump();
        exp_q.push_back(exp_st(0, 1, 0, 0, 5'd17));
        do_go(3'b001);
        wait_cycles(40);
        check("fail_one_pulse", 32'(start_cnt - s0), 32'd1);
        check("fail_pulse_pattern", 32'(last_pat), 32'd0);
        check_sb("fail_status");

        // Engine stalls at 3: timeout
        bus.success_i = 1'b1;
        eng_limit     = 5'd3;
        fail_bump();
        exp_q.push_back(exp_st(0, 1, 0, 1, 5'd3));
        do_go(3'b001);
        wait_cycles(100);
        check_sb("timeout_status");
        eng_limit = 5'd17;

        // Second go while the first run is still in RUN
        s0 = start_cnt;
        exp_q.push_back(exp_st(0, 1, 1, 0, 5'd17));
        do_go(3'b001);
        do_go(3'b011);
        wait_cycles(40);
        check("second_go_ignored", 32'(start_cnt - s0), 32'd1);
        check("second_go_pattern_kept", 32'(bus.pattern_sel_o), 32'd0);
        check_sb("second_go_status");

        // Go with sel_i=0 does nothing; status unchanged
        bus.sel_i = 1'b0;
        s0 = start_cnt;
        do_go(3'b011);
        wait_cycles(10);
        check("unselected_go_ignored", 32'(start_cnt - s0), 32'd0);
        bus.sel_i = 1'b1;
        exp_q.push_back(exp_st(0, 1, 1, 0, 5'd17));
        check_sb("unselected_status");

        // Stale duration 17 from the previous run must not end the new one
        s0 = start_cnt;
        do_go(3'b001);
        wait_cycles(3);
        read_status(st_mid);
        check("stale_still_busy", 32'(st_mid[3:0]), 32'h1);
        exp_q.push_back(exp_st(0, 1, 1, 0, 5'd17));
        wait_cycles(40);
        check("stale_one_pulse", 32'(start_cnt - s0), 32'd1);
        check_sb("stale_status");

        // Reset mid-run
        do_go(3'b011);
        wait_cycles(6);
        trst_n = 1'b0;
        #1;
        check("midreset_tst_start", 32'(bus.tst_start_o), 32'd0);
        check("midreset_pattern_sel", 32'(bus.pattern_sel_o), 32'd0);
        check("midreset_tdo", 32'(bus.tdo_o), 32'd0);
        wait_cycles(2);
        trst_n   = 1'b1;
        fc_model = 4'd0;
        exp_q.push_back(exp_st(0, 0, 0, 0, 5'd0));
        check_sb("midreset_status");

        // Twenty failing runs: counter saturates at 15 when present
        bus.success_i = 1'b0;
        for (int k = 0; k < 20; k++) begin
            do_go(3'b001);
            wait_cycles(25);
            fail_bump();
        end
        exp_q.push_back(exp_st(0, 1, 0, 0, 5'd17));
        check_sb("saturate_status");

        // Go with control bit 2: clears the counter in the counting build, ignored otherwise
        bus.success_i = 1'b1;
`ifdef BIST_FAIL_CNT_EN
        fc_model = 4'd0;
`endif
        exp_q.push_back(exp_st(0, 1, 1, 0, 5'd17));
        do_go(3'b101);
        wait_cycles(40);
        check_sb("clear_bit_status");

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
